// File: rtl/mac_sequencer_pkg.sv
// Shared types and constants for the shift-and-add MAC sequencer.
package mac_sequencer_pkg;
  localparam int OP_W  = 8;
  localparam int ACC_W = 20;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/mac_sequencer_if.sv
// Operand/result handshake bundle between a producer/consumer and the MAC sequencer.
interface mac_sequencer_if #(
  parameter int OP_W  = mac_sequencer_pkg::OP_W,
  parameter int ACC_W = mac_sequencer_pkg::ACC_W
);
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op_a;
  logic [OP_W-1:0]  op_b;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  modport master (
    output in_valid, op_a, op_b, acc_clr, out_ready,
    input  in_ready, out_valid, acc, ovf
  );

  modport slave (
    input  in_valid, op_a, op_b, acc_clr, out_ready,
    output in_ready, out_valid, acc, ovf
  );
endinterface

// File: rtl/N_bit_adder.sv
// N-bit ripple-carry adder; carry-out is the final carry of the chain.
module N_bit_adder #(
  parameter int N = 20
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);
  logic [N:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = c[N];
endmodule

// File: rtl/mac_sequencer.sv
// Fixed-latency unsigned shift-and-add multiply-accumulate: one partial product per BUSY cycle,
// eight BUSY cycles per operand pair, one shared isolated adder.
module mac_sequencer #(
  parameter int OP_W  = 8,
  parameter int ACC_W = 20
) (
  input logic           clk,
  input logic           rst,
  mac_sequencer_if.slave bus
);
  import mac_sequencer_pkg::*;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   mcand_q;
  logic [OP_W-1:0]    mplr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ovf_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic               accept;
  logic               add_en;
  logic [ACC_W-1:0]   add_a;
  logic [ACC_W-1:0]   add_b;
  logic [ACC_W-1:0]   sum;
  logic               cout;

  assign accept = bus.in_valid && in_ready_q;
  assign add_en = (state_q == BUSY) && mplr_q[0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BUSY;
      BUSY:    if (cnt_q == CNT_MAX) state_d = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand isolation: adder inputs sit at zero unless this partial product is used.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (add_en) begin
      add_a = acc_q;
      add_b = mcand_q;
    end
  end

  N_bit_adder #(.N(ACC_W)) u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      case (state_q)
        IDLE: begin
          if (accept) begin
            mcand_q <= {{(ACC_W-OP_W){1'b0}}, bus.op_a};
            mplr_q  <= bus.op_b;
            cnt_q   <= '0;
            if (bus.acc_clr) begin
              acc_q <= '0;
              ovf_q <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (add_en) begin
            acc_q <= sum;
            ovf_q <= ovf_q | cout;
          end
          mcand_q <= mcand_q << 1;
          mplr_q  <= mplr_q >> 1;
          cnt_q   <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: latency, accumulation/wrap, isolation, DONE hold,
// async reset mid-operation and handshake/accept ordering.
module tb_mac_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mac_sequencer_if #(.OP_W(8), .ACC_W(20)) bus ();

  mac_sequencer #(.OP_W(8), .ACC_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int errs   = 0;
  int edges;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present an operand pair and count rising edges, the accept edge included, until
  // out_valid is seen. Inputs are scrambled after accept to show they are ignored.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic clr,
                        input bit iso, output int n);
    bus.op_a     = a;
    bus.op_b     = b;
    bus.acc_clr  = clr;
    bus.in_valid = 1'b1;
    n = 0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op_a     = 8'($urandom);
      bus.op_b     = 8'($urandom);
      bus.acc_clr  = 1'($urandom_range(0, 1));
      if (bus.out_valid) break;
      if (iso) begin
        chk("iso_add_a", 32'(dut.add_a), 32'd0);
        chk("iso_add_b", 32'(dut.add_b), 32'd0);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("hs_in_ready", 32'(bus.in_ready), 32'd1);
    chk("hs_out_valid", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.op_a      = '0;
    bus.op_b      = '0;
    bus.acc_clr   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset takes effect before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_acc", 32'(bus.acc), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;

    // 255*255 from a cleared accumulator: accept edge + 8 BUSY edges.
    run_op(8'd255, 8'd255, 1'b1, 1'b0, edges);
    chk("lat_first", 32'(edges), 32'd9);
    chk("acc_ff", 32'(bus.acc), 32'h0FE01);
    chk("ovf_ff", 32'(bus.ovf), 32'd0);
    handshake();

    for (int i = 1; i < 16; i++) begin
      run_op(8'd255, 8'd255, 1'b0, 1'b0, edges);
      chk("lat_accum", 32'(edges), 32'd9);
      handshake();
    end
    chk("acc_x16", 32'(bus.acc), 32'hFE010);
    chk("ovf_x16", 32'(bus.ovf), 32'd0);

    // 17th product wraps past 2^20.
    run_op(8'd255, 8'd255, 1'b0, 1'b0, edges);
    chk("acc_x17", 32'(bus.acc), 32'h0DE11);
    chk("ovf_x17", 32'(bus.ovf), 32'd1);
    handshake();
    chk("ovf_sticky_idle", 32'(bus.ovf), 32'd1);

    run_op(8'd3, 8'd5, 1'b1, 1'b0, edges);
    chk("acc_3x5", 32'(bus.acc), 32'h0000F);
    chk("ovf_cleared", 32'(bus.ovf), 32'd0);
    handshake();

    // Zero multiplier: no adder activity, acc untouched, same latency.
    run_op(8'hA5, 8'h00, 1'b0, 1'b1, edges);
    chk("lat_zero_b", 32'(edges), 32'd9);
    chk("acc_zero_b", 32'(bus.acc), 32'h0000F);

    // Stall in DONE while the producer keeps poking.
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op_a     = 8'($urandom);
      bus.op_b     = 8'($urandom);
      bus.acc_clr  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("hold_acc", 32'(bus.acc), 32'h0000F);
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_ovf", 32'(bus.ovf), 32'd0);
    end

    // Result handshake with in_valid already high: IDLE first, accept one edge later.
    bus.in_valid  = 1'b1;
    bus.op_a      = 8'd2;
    bus.op_b      = 8'd3;
    bus.acc_clr   = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    chk("b2b_out_valid", 32'(bus.out_valid), 32'd0);
    chk("b2b_acc_kept", 32'(bus.acc), 32'h0000F);
    run_op(8'd2, 8'd3, 1'b1, 1'b0, edges);
    chk("b2b_lat", 32'(edges), 32'd9);
    chk("b2b_acc", 32'(bus.acc), 32'd6);
    handshake();

    // Async reset in the 4th BUSY cycle of 200*100.
    bus.op_a     = 8'd200;
    bus.op_b     = 8'd100;
    bus.acc_clr  = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("arst_acc", 32'(bus.acc), 32'd0);
    chk("arst_ovf", 32'(bus.ovf), 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    #1 rst = 1'b0;

    run_op(8'd7, 8'd9, 1'b0, 1'b0, edges);
    chk("post_rst_lat", 32'(edges), 32'd9);
    chk("post_rst_acc", 32'(bus.acc), 32'd63);
    chk("post_rst_ovf", 32'(bus.ovf), 32'd0);
    handshake();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter OP_W, default 8: operand width; the only supported value is 8.
REQ-002 Parameter ACC_W, default 20: accumulator width; the only supported value is 20.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operand pair and mode are valid.
REQ-006 in_ready  output  1  block can accept an operand pair.
REQ-007 op_a  input  OP_W  multiplicand, unsigned.
REQ-008 op_b  input  OP_W  multiplier, unsigned.
REQ-009 acc_clr  input  1  sampled on accept; 1 starts from zero, 0 accumulates onto the current acc.
REQ-010 out_valid  output  1  acc holds a completed result.
REQ-011 out_ready  input  1  consumer takes the result.
REQ-012 acc  output  ACC_W  accumulator value.
REQ-013 ovf  output  1  sticky flag, set on any adder carry-out since the last clear.

Function
REQ-014 States: IDLE, BUSY, DONE. in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 Accept: in_valid&&in_ready at a rising edge SHALL:
- latch op_a into a 20-bit shift register mcand (zero-extended);
- latch op_b into an 8-bit shift register mplr;
- clear acc and ovf if acc_clr=1;
- clear the bit counter cnt;
- go to BUSY.
REQ-016 BUSY, each edge:
- if mplr[0]=1, acc <= acc + mcand through the single shared adder;
- mcand <<= 1; mplr >>= 1; cnt++.
REQ-017 After the 8th BUSY edge (cnt=7) the block SHALL go to DONE. out_valid SHALL rise exactly 9 edges after the accept edge.
REQ-018 Latency is fixed at 8 BUSY cycles regardless of operand values; there is no early termination.
REQ-019 Low power: when mplr[0]=0, both adder inputs SHALL be forced to zero (operand isolation) and acc SHALL not be written.
REQ-020 Arithmetic: sums wrap modulo 2^20. A carry-out from any BUSY add SHALL set ovf, and ovf SHALL hold until the next accept with acc_clr=1 or reset.
REQ-021 DONE: acc, ovf and out_valid SHALL hold while out_ready=0. On out_valid&&out_ready the block SHALL return to IDLE; acc stays valid there for later accumulation.
REQ-022 in_valid SHALL be ignored outside IDLE. There is no same-cycle DONE->BUSY transition; a new operand pair is accepted no earlier than 1 cycle after the result handshake.
REQ-023 op_a, op_b and acc_clr changing during BUSY or DONE SHALL not affect the result.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, acc=0, ovf=0, cnt=0, mcand=0 and mplr=0, which gives in_ready=1 and out_valid=0, without waiting for a clock edge.
REQ-025 rst asserted mid-BUSY or in DONE SHALL abandon the operation with no partial result retained.
REQ-026 Deassertion SHALL take effect on the first clock edge after rst falls; the block is then in IDLE and ready.

Structure
REQ-027 A shared package SHALL hold the state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the constants OP_W=8, ACC_W=20 and the bit-count limit 7.
REQ-028 The block SHALL instantiate exactly one sub-module, the team's 20-bit ripple adder N_bit_adder. The adder carry-out SHALL be taken from a 21-bit sum, by extending the inputs with 1'b0 or by a separate carry computation.
REQ-029 State SHALL use a single always block with async reset; next-state and adder-input isolation SHALL be combinational logic.

Verification
REQ-030 Reset, then accept a=255, b=255, clr=1 -> out_valid rises 9 edges after accept; acc=0xFE01, ovf=0.
REQ-031 16 accepts of a=255, b=255 (clr=1 first, then clr=0) -> acc=0xFE010, ovf=0. A 17th accept -> acc=0x0DE11, ovf=1. Next accept with clr=1, a=3, b=5 -> acc=0x0000F, ovf=0.
REQ-032 Accept a=0xA5, b=0x00 -> acc unchanged and no adder activity (adder inputs 0) on all 8 BUSY cycles; out_valid at +9.
REQ-033 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and operands -> acc, ovf and out_valid stable; in_ready=0; no new accept.
REQ-034 Assert rst at the 4th BUSY cycle of a=200, b=100 -> acc=0, ovf=0, in_ready=1 with no clock edge required; a following accept of a=7, b=9, clr=0 -> acc=63.
REQ-035 Result handshake and in_valid=1 in the same cycle -> next cycle IDLE with in_ready=1; accept occurs on the following edge only.
